adc_touch_ctrl: RTL and testbench

Frame sequencer for the serial touch-screen ADC. Waits for a pen-down interrupt, then runs 80-count conversion frames. In each frame it drives the chip select, the serial clock and the modulo-80 `Cuenta` bus that feeds the DIN command generator. It shifts in the 12-bit X and Y results and presents them with a one-cycle valid strobe. It sits between the ADC pins and the coordinate consumer logic, and owns the only counter that the DIN generator observes.

---
 rtl/adc_touch_ctrl_pkg.sv | 39 +++
 rtl/adc_touch_ctrl_tick_gen.sv | 35 +++
 rtl/adc_touch_ctrl.sv | 153 +++++++++++++++
 tb/tb_adc_touch_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_touch_ctrl_pkg.sv
// adc_touch_ctrl_pkg
// Shared definitions for the touch-screen ADC frame sequencer and the DIN
// command generator that sits beside it. Both sides import this package so
// the frame layout, the sampling windows and the command bytes stay in step.
//   FRAME_LEN       : counts per conversion frame (Cuenta runs 0..FRAME_LEN-1)
//   X_FIRST/X_LAST  : odd counts on which the X result bits are sampled
//   Y_FIRST/Y_LAST  : odd counts on which the Y result bits are sampled
//   DIN_x/DIN_y     : control bytes the DIN generator shifts out for X and Y
//   state_t         : sequencer states
package adc_touch_ctrl_pkg;

  localparam int FRAME_LEN = 80;
  localparam int CNT_W     = 7;
  localparam int DATA_W    = 12;

  localparam int X_FIRST = 19;
  localparam int X_LAST  = 41;
  localparam int Y_FIRST = 51;
  localparam int Y_LAST  = 73;

  // Start bit, channel select, 12-bit mode, differential reference,
  // power-down between conversions so PENIRQ stays armed.
  localparam logic [7:0] DIN_x = 8'hD0;
  localparam logic [7:0] DIN_y = 8'h90;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // DOUT bits are taken at the end of the DCLK-high half of a bit, which is
  // the tick leaving an odd count inside the channel's window.
  function automatic logic in_window(input logic [CNT_W-1:0] count,
                                     input int first, input int last);
    return count[0] && (int'(count) >= first) && (int'(count) <= last);
  endfunction

endpackage

// File: rtl/adc_touch_ctrl_tick_gen.sv
// tick_gen
// Count prescaler for the frame sequencer. Counts 0..DIV-1 and flags the last
// system clock of each count period. A synchronous clear parks the counter at
// zero so a new frame always starts with a full-length first count.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   clear : synchronous clear, also suppresses tick
//   tick  : high on the cycle where the prescaler sits at DIV-1
module tick_gen #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/adc_touch_ctrl.sv
// adc_touch_ctrl
// Frame sequencer for the serial touch-screen ADC. After a pen-down it runs
// back-to-back 80-count frames, driving chip select, DCLK and the Cuenta
// count observed by the DIN generator, and shifts in the 12-bit X and Y
// results. A frame whose pen stayed down throughout updates X/Y with a
// one-cycle Valid strobe.
//   CLK      : system clock          RST_n    : async active-low reset
//   Enable   : run permission        PENIRQ_n : async pen-down, active low
//   ADC_DOUT : serial ADC data       ADC_CS_n : chip select, active low
//   ADC_DCLK : serial clock          Cuenta   : frame count 0..79
//   Gen_En   : DIN generator enable  X, Y     : last good results
//   Valid    : strobe when X/Y update
module adc_touch_ctrl
  import adc_touch_ctrl_pkg::*;
#(
  parameter int DIV = 25
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Enable,
  input  logic              PENIRQ_n,
  input  logic              ADC_DOUT,
  output logic              ADC_CS_n,
  output logic              ADC_DCLK,
  output logic [CNT_W-1:0]  Cuenta,
  output logic              Gen_En,
  output logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] Y,
  output logic              Valid
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_LEN - 1);

  state_t            state;
  logic [1:0]        pen_sync;
  logic              pen;
  logic              pen_ok;
  logic              tick;
  logic              tick_clear;
  logic [DATA_W-1:0] sh_x;
  logic [DATA_W-1:0] sh_y;

  // Two-flop synchronizer; resets to "pen up" so reset never starts a frame.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pen_sync <= 2'b11;
    end else begin
      pen_sync <= {pen_sync[0], PENIRQ_n};
    end
  end

  assign pen = ~pen_sync[1];

  // Held at zero outside CONV and while aborting, so every frame starts clean.
  assign tick_clear = (state != CONV) || !Enable;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (CLK),
    .rst_n(RST_n),
    .clear(tick_clear),
    .tick (tick)
  );

  // All pin-facing outputs are assigned together with the state they belong
  // to, so CS_n, Gen_En, DCLK and Cuenta switch on the same edge as the state.
  // pen_ok remembers whether the pen stayed down for the whole frame.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      Cuenta   <= '0;
      ADC_CS_n <= 1'b1;
      ADC_DCLK <= 1'b0;
      Gen_En   <= 1'b0;
      X        <= '0;
      Y        <= '0;
      Valid    <= 1'b0;
      sh_x     <= '0;
      sh_y     <= '0;
      pen_ok   <= 1'b0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable && pen) begin
            state    <= CONV;
            Cuenta   <= '0;
            ADC_CS_n <= 1'b0;
            ADC_DCLK <= 1'b0;
            Gen_En   <= 1'b1;
            pen_ok   <= 1'b1;
          end
        end

        CONV: begin
          if (!pen) begin
            pen_ok <= 1'b0;
          end
          // Abort takes priority over everything, including the final tick.
          if (!Enable) begin
            state    <= IDLE;
            Cuenta   <= '0;
            ADC_CS_n <= 1'b1;
            ADC_DCLK <= 1'b0;
            Gen_En   <= 1'b0;
          end else if (tick) begin
            if (in_window(Cuenta, X_FIRST, X_LAST)) begin
              sh_x <= {sh_x[DATA_W-2:0], ADC_DOUT};
            end
            if (in_window(Cuenta, Y_FIRST, Y_LAST)) begin
              sh_y <= {sh_y[DATA_W-2:0], ADC_DOUT};
            end
            if (Cuenta == LAST_COUNT) begin
              state    <= DONE;
              Cuenta   <= '0;
              ADC_CS_n <= 1'b1;
              ADC_DCLK <= 1'b0;
              Gen_En   <= 1'b0;
            end else begin
              Cuenta   <= Cuenta + CNT_W'(1);
              // DCLK follows bit 0 of the count being entered.
              ADC_DCLK <= ~Cuenta[0];
            end
          end
        end

        DONE: begin
          if (pen_ok && pen) begin
            X     <= sh_x;
            Y     <= sh_y;
            Valid <= 1'b1;
          end
          if (Enable && pen) begin
            state    <= CONV;
            Cuenta   <= '0;
            ADC_CS_n <= 1'b0;
            ADC_DCLK <= 1'b0;
            Gen_En   <= 1'b1;
            pen_ok   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_touch_ctrl.sv
// tb_adc_touch_ctrl
// Self-checking bench for adc_touch_ctrl with DIV=4. A behavioural ADC model
// counts DCLK rising edges within a chip-select frame and returns random X/Y
// words; expected results with their exact arrival cycle are queued by the
// stimulus and consumed by an independent monitor watching Valid.
module tb_adc_touch_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 80 * DIV + 1;

  logic        CLK;
  logic        RST_n;
  logic        Enable;
  logic        PENIRQ_n;
  logic        ADC_DOUT;
  logic        ADC_CS_n;
  logic        ADC_DCLK;
  logic [6:0]  Cuenta;
  logic        Gen_En;
  logic [11:0] X;
  logic [11:0] Y;
  logic        Valid;

  typedef struct {
    int cyc;
    int x;
    int y;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] adc_xq[$];
  logic [11:0] adc_yq[$];

  int n_cmp;
  int n_bad;
  int cyc;
  int last_x;
  int last_y;

  adc_touch_ctrl #(
    .DIV(DIV)
  ) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .Enable  (Enable),
    .PENIRQ_n(PENIRQ_n),
    .ADC_DOUT(ADC_DOUT),
    .ADC_CS_n(ADC_CS_n),
    .ADC_DCLK(ADC_DCLK),
    .Cuenta  (Cuenta),
    .Gen_En  (Gen_En),
    .X       (X),
    .Y       (Y),
    .Valid   (Valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Number of rising clock edges seen so far.
  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // ADC model: MSB-first X after DCLK rise 10..21, Y after rise 26..37,
  // random noise on every other rise so wrong sampling windows show up.
  initial begin : adc_model
    int          nrise;
    bit          in_frame;
    logic        prev;
    logic [11:0] cx;
    logic [11:0] cy;
    ADC_DOUT = 1'b0;
    nrise    = 0;
    in_frame = 0;
    prev     = 1'b0;
    cx       = '0;
    cy       = '0;
    forever begin
      @(negedge CLK);
      if (ADC_CS_n) begin
        in_frame = 0;
        nrise    = 0;
      end else begin
        if (!in_frame) begin
          in_frame = 1;
          if (adc_xq.size() > 0) begin
            cx = adc_xq.pop_front();
            cy = adc_yq.pop_front();
          end else begin
            cx = '0;
            cy = '0;
          end
        end
        if (ADC_DCLK && !prev) begin
          nrise++;
          if (nrise >= 10 && nrise <= 21) ADC_DOUT = cx[21-nrise];
          else if (nrise >= 26 && nrise <= 37) ADC_DOUT = cy[37-nrise];
          else ADC_DOUT = 1'($urandom_range(0, 1));
        end
      end
      prev = ADC_DCLK;
    end
  end

  // Monitor: every Valid must match the next queued result and its cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_valid: got Valid=1 at cycle %0d required no strobe", cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("valid_cycle", cyc, e.cyc);
          checkOutput("X_result", int'(X), e.x);
          checkOutput("Y_result", int'(Y), e.y);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] timeout");
  end

  // n back-to-back good frames, stopped by dropping Enable in the last DONE.
  task automatic applyGoodFrames(input int n);
    int p, s, o, d;
    logic [11:0] vx, vy;
    p = cyc;
    for (int i = 0; i < n; i++) begin
      vx = 12'($urandom_range(0, 4095));
      vy = 12'($urandom_range(0, 4095));
      adc_xq.push_back(vx);
      adc_yq.push_back(vy);
      exp_q.push_back('{p + 3 + FRAME * (i + 1), int'(vx), int'(vy)});
      last_x = int'(vx);
      last_y = int'(vy);
    end
    Enable   = 1'b1;
    PENIRQ_n = 1'b0;
    waitUntil(p + 2);
    checkOutput("cs_before_conv", int'(ADC_CS_n), 1);
    s = p + 3;
    waitUntil(s);
    checkOutput("cs_enter_conv", int'(ADC_CS_n), 0);
    checkOutput("gen_en_conv", int'(Gen_En), 1);
    checkOutput("cuenta_start", int'(Cuenta), 0);
    o = 0;
    while (1) begin
      o += $urandom_range(1, 37);
      if (o >= 320) break;
      waitUntil(s + o);
      checkOutput("cuenta_in_frame", int'(Cuenta), o / DIV);
      checkOutput("dclk_in_frame", int'(ADC_DCLK), (o / DIV) % 2);
    end
    waitUntil(s + 319);
    checkOutput("cuenta_last", int'(Cuenta), 79);
    waitUntil(s + 320);
    checkOutput("cs_done", int'(ADC_CS_n), 1);
    checkOutput("gen_en_done", int'(Gen_En), 0);
    checkOutput("cuenta_wrap", int'(Cuenta), 0);
    if (n > 1) begin
      waitUntil(s + 321);
      checkOutput("cs_next_frame", int'(ADC_CS_n), 0);
      checkOutput("cuenta_next_frame", int'(Cuenta), 0);
    end
    d = s + FRAME * (n - 1) + 320;
    waitUntil(d);
    Enable = 1'b0;
    waitUntil(d + 1);
    checkOutput("cs_idle_after", int'(ADC_CS_n), 1);
    checkOutput("gen_en_idle_after", int'(Gen_En), 0);
    PENIRQ_n = 1'b1;
    waitUntil(d + 5);
    Enable = 1'b1;
  endtask

  // Enable dropped during count 'at'; at 79 it lands on the final tick.
  task automatic applyAbort(input int at);
    int p, off, d;
    p = cyc;
    adc_xq.push_back(12'($urandom_range(0, 4095)));
    adc_yq.push_back(12'($urandom_range(0, 4095)));
    Enable   = 1'b1;
    PENIRQ_n = 1'b0;
    off = (at == 79) ? DIV - 1 : $urandom_range(0, DIV - 1);
    d = p + 3 + DIV * at + off;
    waitUntil(d);
    checkOutput("cuenta_before_abort", int'(Cuenta), at);
    Enable = 1'b0;
    waitUntil(d + 1);
    checkOutput("cs_abort", int'(ADC_CS_n), 1);
    checkOutput("cuenta_abort", int'(Cuenta), 0);
    checkOutput("dclk_abort", int'(ADC_DCLK), 0);
    checkOutput("gen_en_abort", int'(Gen_En), 0);
    waitUntil(d + 2);
    checkOutput("valid_abort", int'(Valid), 0);
    checkOutput("x_kept_abort", int'(X), last_x);
    checkOutput("y_kept_abort", int'(Y), last_y);
    PENIRQ_n = 1'b1;
    waitUntil(d + 6);
    Enable = 1'b1;
  endtask

  // Pen released during count 'at': frame runs out, result discarded.
  task automatic applyPenLift(input int at);
    int p, s;
    p = cyc;
    adc_xq.push_back(12'($urandom_range(0, 4095)));
    adc_yq.push_back(12'($urandom_range(0, 4095)));
    Enable   = 1'b1;
    PENIRQ_n = 1'b0;
    s = p + 3;
    waitUntil(s + DIV * at);
    PENIRQ_n = 1'b1;
    waitUntil(s + 319);
    checkOutput("cuenta_lift_last", int'(Cuenta), 79);
    checkOutput("cs_lift_running", int'(ADC_CS_n), 0);
    waitUntil(s + 320);
    checkOutput("cs_lift_done", int'(ADC_CS_n), 1);
    waitUntil(s + 321);
    checkOutput("valid_lift", int'(Valid), 0);
    checkOutput("x_kept_lift", int'(X), last_x);
    checkOutput("y_kept_lift", int'(Y), last_y);
    waitUntil(s + 330);
    checkOutput("cs_lift_idle", int'(ADC_CS_n), 1);
    checkOutput("cuenta_lift_idle", int'(Cuenta), 0);
  endtask

  // Reset asserted while Cuenta=45; outputs must clear without a clock edge.
  task automatic applyMidReset();
    int p, d;
    p = cyc;
    adc_xq.push_back(12'($urandom_range(0, 4095)));
    adc_yq.push_back(12'($urandom_range(0, 4095)));
    Enable   = 1'b1;
    PENIRQ_n = 1'b0;
    d = p + 3 + DIV * 45 + 1;
    waitUntil(d);
    checkOutput("cuenta_before_reset", int'(Cuenta), 45);
    RST_n = 1'b0;
    #1;
    checkOutput("rst_cs", int'(ADC_CS_n), 1);
    checkOutput("rst_dclk", int'(ADC_DCLK), 0);
    checkOutput("rst_cuenta", int'(Cuenta), 0);
    checkOutput("rst_gen_en", int'(Gen_En), 0);
    checkOutput("rst_x", int'(X), 0);
    checkOutput("rst_y", int'(Y), 0);
    checkOutput("rst_valid", int'(Valid), 0);
    last_x   = 0;
    last_y   = 0;
    PENIRQ_n = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    d = cyc;
    waitUntil(d + 20);
    checkOutput("cs_quiet_after_reset", int'(ADC_CS_n), 1);
    checkOutput("gen_en_quiet_after_reset", int'(Gen_En), 0);
    checkOutput("cuenta_quiet_after_reset", int'(Cuenta), 0);
  endtask

  initial begin : applyStimulus
    n_cmp    = 0;
    n_bad    = 0;
    last_x   = 0;
    last_y   = 0;
    RST_n    = 1'b0;
    Enable   = 1'b0;
    PENIRQ_n = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("reset_cs", int'(ADC_CS_n), 1);
    checkOutput("reset_dclk", int'(ADC_DCLK), 0);
    checkOutput("reset_cuenta", int'(Cuenta), 0);
    checkOutput("reset_gen_en", int'(Gen_En), 0);
    checkOutput("reset_x", int'(X), 0);
    checkOutput("reset_y", int'(Y), 0);
    checkOutput("reset_valid", int'(Valid), 0);
    RST_n = 1'b1;
    repeat (3) @(negedge CLK);
    Enable = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] single good frame");
    applyGoodFrames(1);
    $display("[TB] three continuous frames");
    applyGoodFrames(3);
    $display("[TB] aborts");
    applyAbort(30);
    applyAbort(79);
    applyAbort($urandom_range(1, 78));
    $display("[TB] pen lifts");
    applyPenLift(60);
    applyPenLift($urandom_range(1, 79));
    $display("[TB] reset mid-frame");
    applyMidReset();
    $display("[TB] good frames after reset");
    applyGoodFrames(2);

    repeat (10) @(negedge CLK);
    checkOutput("expected_queue_drained", exp_q.size(), 0);
    checkOutput("adc_queue_drained", adc_xq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
